// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller.
// Selector encodings, duration type and factory-default durations.
package traffic_pkg;

    typedef logic [3:0] tparam_t;
    typedef logic [1:0] sel_t;

    localparam sel_t SEL_BASE = 2'b00;
    localparam sel_t SEL_EXT  = 2'b01;
    localparam sel_t SEL_YEL  = 2'b10;
    localparam sel_t SEL_NONE = 2'b11;

    localparam tparam_t TP_DEF_BASE = 4'd6;
    localparam tparam_t TP_DEF_EXT  = 4'd3;
    localparam tparam_t TP_DEF_YEL  = 4'd2;

    localparam tparam_t TP_ZERO = 4'd0;

    // A zero duration is illegal, so it is replaced by the default.
    function automatic tparam_t sanitize(input tparam_t v, input tparam_t def);
        return (v == TP_ZERO) ? def : v;
    endfunction

endpackage

// File: rtl/time_parameters_tparam_reg.sv
// Single 4-bit timing parameter: sync reset to default, write enable,
// and zero-means-default substitution on writes.
module tparam_reg
    import traffic_pkg::*;
#(
    parameter tparam_t DEF = TP_DEF_BASE
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    we,
    input  tparam_t wdata,
    output tparam_t value
);

    tparam_t val_d;
    tparam_t val_q;

    always_comb begin
        val_d = val_q;
        if (we) begin
            val_d = sanitize(wdata, DEF);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= DEF;
        end else begin
            val_q <= val_d;
        end
    end

    assign value = val_q;

endmodule

// File: rtl/time_parameters.sv
// Timing-parameter register file: three durations, reprogrammable at
// run time, with a zero-latency read mux selected by the controller.
module time_parameters
    import traffic_pkg::*;
#(
    parameter tparam_t DEF_BASE = TP_DEF_BASE,
    parameter tparam_t DEF_EXT  = TP_DEF_EXT,
    parameter tparam_t DEF_YEL  = TP_DEF_YEL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] selector,
    input  logic [1:0] selector_reprogram,
    input  logic [3:0] t_value_input,
    input  logic       reprogram,
    output logic [3:0] t_value_output
);

    logic    we_base;
    logic    we_ext;
    logic    we_yel;
    tparam_t t_base;
    tparam_t t_ext;
    tparam_t t_yel;

    always_comb begin
        we_base = reprogram && (selector_reprogram == SEL_BASE);
        we_ext  = reprogram && (selector_reprogram == SEL_EXT);
        we_yel  = reprogram && (selector_reprogram == SEL_YEL);
    end

    tparam_reg #(.DEF(DEF_BASE)) u_base (
        .clk   (clk),
        .reset (reset),
        .we    (we_base),
        .wdata (t_value_input),
        .value (t_base)
    );

    tparam_reg #(.DEF(DEF_EXT)) u_ext (
        .clk   (clk),
        .reset (reset),
        .we    (we_ext),
        .wdata (t_value_input),
        .value (t_ext)
    );

    tparam_reg #(.DEF(DEF_YEL)) u_yel (
        .clk   (clk),
        .reset (reset),
        .we    (we_yel),
        .wdata (t_value_input),
        .value (t_yel)
    );

    always_comb begin
        t_value_output = TP_ZERO;
        case (selector)
            SEL_BASE: t_value_output = t_base;
            SEL_EXT:  t_value_output = t_ext;
            SEL_YEL:  t_value_output = t_yel;
            default:  t_value_output = TP_ZERO;
        endcase
    end

endmodule

// File: tb/tb_time_parameters.sv
// Directed scoreboard bench for time_parameters (default and
// overridden factory values).
module tb_time_parameters;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] selector = SEL_BASE;
    logic [1:0] selector_reprogram = SEL_NONE;
    logic [3:0] t_value_input = 4'd0;
    logic       reprogram = 1'b0;
    logic [3:0] out_a;
    logic [3:0] out_b;

    typedef struct {
        string    tag;
        bit       dut_b;
        logic [3:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    time_parameters dut_a (
        .clk                (clk),
        .reset              (reset),
        .selector           (selector),
        .selector_reprogram (selector_reprogram),
        .t_value_input      (t_value_input),
        .reprogram          (reprogram),
        .t_value_output     (out_a)
    );

    time_parameters #(
        .DEF_BASE (4'd8),
        .DEF_EXT  (4'd4),
        .DEF_YEL  (4'd3)
    ) dut_b (
        .clk                (clk),
        .reset              (reset),
        .selector           (selector),
        .selector_reprogram (selector_reprogram),
        .t_value_input      (t_value_input),
        .reprogram          (reprogram),
        .t_value_output     (out_b)
    );

    task automatic drive(input logic rs, input logic rp,
                         input logic [1:0] srp, input logic [3:0] v,
                         input logic [1:0] sel);
        @(posedge clk);
        #1;
        reset = rs;
        reprogram = rp;
        selector_reprogram = srp;
        t_value_input = v;
        selector = sel;
    endtask

    task automatic expect_a(input string tag, input logic [3:0] e);
        sb_q.push_back('{tag: tag, dut_b: 1'b0, exp: e});
    endtask

    task automatic expect_b(input string tag, input logic [3:0] e);
        sb_q.push_back('{tag: tag, dut_b: 1'b1, exp: e});
    endtask

    task automatic settle();
        sb_t e;
        logic [3:0] obs;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs = e.dut_b ? out_b : out_a;
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d",
                       e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic rd(input logic [1:0] sel, input string tag,
                      input logic [3:0] ea, input logic [3:0] eb);
        drive(1'b0, 1'b0, SEL_NONE, 4'd0, sel);
        expect_a({tag, "_a"}, ea);
        expect_b({tag, "_b"}, eb);
        settle();
    endtask

    initial begin
        // 1: reset, then sweep selector
        drive(1'b1, 1'b0, SEL_NONE, 4'd0, SEL_BASE);
        drive(1'b1, 1'b0, SEL_NONE, 4'd0, SEL_BASE);
        rd(SEL_BASE, "rst_base", 4'd6, 4'd8);
        rd(SEL_EXT,  "rst_ext",  4'd3, 4'd4);
        rd(SEL_YEL,  "rst_yel",  4'd2, 4'd3);
        rd(SEL_NONE, "rst_none", 4'd0, 4'd0);

        // 2: write 10 to BASE, old value visible during the write cycle
        drive(1'b0, 1'b1, SEL_BASE, 4'd10, SEL_BASE);
        expect_a("wr_base_old", 4'd6);
        settle();
        rd(SEL_BASE, "wr_base_new", 4'd10, 4'd10);
        rd(SEL_EXT,  "ext_keep",    4'd3,  4'd4);
        rd(SEL_YEL,  "yel_keep",    4'd2,  4'd3);

        // 3: back-to-back writes EXT=15, YEL=1
        drive(1'b0, 1'b1, SEL_EXT, 4'd15, SEL_EXT);
        expect_a("wr_ext_old", 4'd3);
        settle();
        drive(1'b0, 1'b1, SEL_YEL, 4'd1, SEL_YEL);
        expect_a("wr_yel_old", 4'd2);
        settle();
        rd(SEL_EXT,  "ext_15",     4'd15, 4'd15);
        rd(SEL_YEL,  "yel_1",      4'd1,  4'd1);
        rd(SEL_BASE, "base_still", 4'd10, 4'd10);

        // 4: zero write falls back to default; selector 11 writes nothing
        drive(1'b0, 1'b1, SEL_BASE, 4'd0, SEL_BASE);
        expect_a("zero_old", 4'd10);
        settle();
        rd(SEL_BASE, "zero_base", 4'd6, 4'd8);
        drive(1'b0, 1'b1, SEL_NONE, 4'd7, SEL_NONE);
        expect_a("none_wr_out", 4'd0);
        settle();
        rd(SEL_BASE, "none_base", 4'd6,  4'd8);
        rd(SEL_EXT,  "none_ext",  4'd15, 4'd15);
        rd(SEL_YEL,  "none_yel",  4'd1,  4'd1);

        // read one register while writing another
        drive(1'b0, 1'b1, SEL_EXT, 4'd5, SEL_YEL);
        expect_a("xrd_yel", 4'd1);
        settle();
        rd(SEL_EXT, "xrd_ext", 4'd5, 4'd5);

        // held reprogram writes on every edge, same result
        drive(1'b0, 1'b1, SEL_YEL, 4'd4, SEL_YEL);
        drive(1'b0, 1'b1, SEL_YEL, 4'd4, SEL_YEL);
        expect_a("hold_yel", 4'd4);
        settle();

        // 5: reset wins over a same-edge write
        drive(1'b1, 1'b1, SEL_YEL, 4'd9, SEL_YEL);
        expect_a("rst_wr_old", 4'd4);
        settle();
        rd(SEL_YEL,  "rst_wr_yel",  4'd2, 4'd3);
        rd(SEL_EXT,  "rst_wr_ext",  4'd3, 4'd4);
        rd(SEL_BASE, "rst_wr_base", 4'd6, 4'd8);

        // later reset after several writes
        drive(1'b0, 1'b1, SEL_BASE, 4'd12, SEL_BASE);
        drive(1'b0, 1'b1, SEL_EXT,  4'd9,  SEL_BASE);
        drive(1'b0, 1'b1, SEL_YEL,  4'd11, SEL_BASE);
        expect_a("pre_rst_base", 4'd12);
        settle();
        rd(SEL_EXT, "pre_rst_ext", 4'd9,  4'd9);
        rd(SEL_YEL, "pre_rst_yel", 4'd11, 4'd11);
        drive(1'b1, 1'b0, SEL_NONE, 4'd0, SEL_BASE);
        rd(SEL_BASE, "rst2_base", 4'd6, 4'd8);
        rd(SEL_EXT,  "rst2_ext",  4'd3, 4'd4);
        rd(SEL_YEL,  "rst2_yel",  4'd2, 4'd3);

        // 6: zero write on EXT and YEL uses each instance's default
        drive(1'b0, 1'b1, SEL_EXT, 4'd13, SEL_EXT);
        drive(1'b0, 1'b1, SEL_EXT, 4'd0,  SEL_EXT);
        expect_b("b_ext_13", 4'd13);
        settle();
        rd(SEL_EXT, "zero_ext", 4'd3, 4'd4);
        drive(1'b0, 1'b1, SEL_YEL, 4'd0, SEL_YEL);
        settle();
        rd(SEL_YEL, "zero_yel", 4'd2, 4'd3);

        // deasserted reprogram causes no write
        drive(1'b0, 1'b0, SEL_BASE, 4'd14, SEL_BASE);
        expect_a("nowr_old", 4'd6);
        settle();
        rd(SEL_BASE, "nowr_base", 4'd6, 4'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
